alu_sequencer: RTL and testbench

//  Fetch/decode/execute controller for the 8-bit accumulator ALU. Reads instructions from a

---
 rtl/alu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit accumulator ALU.
// Three cycles per instruction; keeps a carry flag for conditional jumps.
module alu_sequencer #(
  parameter int PC_WIDTH     = 8,
  parameter int RA_WIDTH     = 3,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [OPCODE_WIDTH+7:0] instr,
  input  logic                    alu_cy,
  output logic [PC_WIDTH-1:0]     pc,
  output logic                    alu_ce,
  output logic                    cy_ce,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [RA_WIDTH-1:0]     reg_addr,
  output logic                    busy,
  output logic                    halted
);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h0);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD  = OPCODE_WIDTH'(4'h2);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(4'h3);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(4'h4);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4'h5);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOT = OPCODE_WIDTH'(4'h6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h8);
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'h9);
  localparam logic [OPCODE_WIDTH-1:0] OP_JNC = OPCODE_WIDTH'(4'hA);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  function automatic logic is_carry_op(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic is_alu_op(input logic [OPCODE_WIDTH-1:0] op);
    return is_carry_op(op) || (op == OP_LD) || (op == OP_AND) || (op == OP_OR) ||
           (op == OP_XOR) || (op == OP_NOT);
  endfunction

  state_t                  state_r, state_s;
  logic [PC_WIDTH-1:0]     pc_r, pc_s, pc_inc_s, target_s;
  logic [OPCODE_WIDTH+7:0] ir_r, ir_s;
  logic [OPCODE_WIDTH-1:0] ir_op_s;
  logic                    cflag_r, cflag_s;
  logic [OPCODE_WIDTH-1:0] opcode_r, opcode_s;
  logic [RA_WIDTH-1:0]     reg_addr_r, reg_addr_s;
  logic                    alu_ce_r, alu_ce_s;
  logic                    cy_ce_r, cy_ce_s;
  logic                    busy_r, busy_s;
  logic                    halted_r, halted_s;

  assign ir_op_s  = ir_r[OPCODE_WIDTH+7:8];
  assign target_s = ir_r[PC_WIDTH-1:0];
  assign pc_inc_s = pc_r + PC_WIDTH'(1);

  // Next-state, next-pc, carry flag and registered-output decode
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    ir_s       = ir_r;
    cflag_s    = cflag_r;
    opcode_s   = opcode_r;
    reg_addr_s = reg_addr_r;
    case (state_r)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_s    = '0;
          cflag_s = 1'b0;
          state_s = S_FETCH;
        end else begin
          state_s = state_r;
        end
      end
      S_FETCH: state_s = S_DECODE;
      S_DECODE: begin
        ir_s       = instr;
        opcode_s   = instr[OPCODE_WIDTH+7:8];
        reg_addr_s = instr[RA_WIDTH-1:0];
        state_s    = S_EXEC;
      end
      S_EXEC: begin
        state_s = S_FETCH;
        // ALU has just produced cy on this cycle's negedge; logic ops leave no carry
        if (is_carry_op(ir_op_s)) begin
          cflag_s = alu_cy;
        end else if (is_alu_op(ir_op_s)) begin
          cflag_s = 1'b0;
        end else begin
          cflag_s = cflag_r;
        end
        case (ir_op_s)
          OP_JMP: pc_s = target_s;
          OP_JC:  pc_s = cflag_r ? target_s : pc_inc_s;
          OP_JNC: pc_s = cflag_r ? pc_inc_s : target_s;
          OP_HLT: begin
            pc_s    = pc_r;
            state_s = S_HALT;
          end
          default: pc_s = pc_inc_s;
        endcase
      end
      default: state_s = S_IDLE;
    endcase
    alu_ce_s = (state_s == S_EXEC) && is_alu_op(opcode_s);
    cy_ce_s  = (state_s == S_EXEC) && is_carry_op(opcode_s);
    busy_s   = (state_s == S_FETCH) || (state_s == S_DECODE) || (state_s == S_EXEC);
    halted_s = (state_s == S_HALT);
  end

  // State, program counter, instruction and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      pc_r    <= '0;
      ir_r    <= '0;
      cflag_r <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      ir_r    <= ir_s;
      cflag_r <= cflag_s;
    end
  end

  // Registered ALU controls and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_r   <= '0;
      reg_addr_r <= '0;
      alu_ce_r   <= 1'b0;
      cy_ce_r    <= 1'b0;
      busy_r     <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      opcode_r   <= opcode_s;
      reg_addr_r <= reg_addr_s;
      alu_ce_r   <= alu_ce_s;
      cy_ce_r    <= cy_ce_s;
      busy_r     <= busy_s;
      halted_r   <= halted_s;
    end
  end

  assign pc       = pc_r;
  assign alu_ce   = alu_ce_r;
  assign cy_ce    = cy_ce_r;
  assign opcode   = opcode_r;
  assign reg_addr = reg_addr_r;
  assign busy     = busy_r;
  assign halted   = halted_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ROM, register file and accumulator ALU around the DUT,
// checked cycle by cycle against an instruction-level reference model.
module tb_alu_sequencer;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_LD = 4'h2, OP_AND = 4'h3,
                         OP_OR = 4'h4, OP_XOR = 4'h5, OP_NOT = 4'h6, OP_JMP = 4'h8,
                         OP_JC = 4'h9, OP_JNC = 4'hA, OP_HLT = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] instr;
  logic        alu_cy;
  logic [7:0]  pc;
  logic        alu_ce, cy_ce;
  logic [3:0]  opcode;
  logic [2:0]  reg_addr;
  logic        busy, halted;

  logic [11:0] rom [256];
  logic [7:0]  regs [8];
  logic [7:0]  acc;
  logic [7:0]  rdat;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_pc;
  logic       m_cf;
  logic [7:0] m_acc;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .alu_cy(alu_cy),
    .pc(pc), .alu_ce(alu_ce), .cy_ce(cy_ce), .opcode(opcode), .reg_addr(reg_addr),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr <= rom[pc];

  assign rdat = regs[reg_addr];

  // Environment ALU: acts on negedge when enabled, clears cy otherwise
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 8'h00; alu_cy <= 1'b0;
    end else if (alu_ce) begin
      case (opcode)
        OP_ADD:  {alu_cy, acc} <= {1'b0, acc} + {1'b0, rdat};
        OP_SUB:  {alu_cy, acc} <= {1'b0, acc} - {1'b0, rdat};
        OP_LD:   begin acc <= rdat;        alu_cy <= 1'b0; end
        OP_AND:  begin acc <= acc & rdat;  alu_cy <= 1'b0; end
        OP_OR:   begin acc <= acc | rdat;  alu_cy <= 1'b0; end
        OP_XOR:  begin acc <= acc ^ rdat;  alu_cy <= 1'b0; end
        OP_NOT:  begin acc <= ~acc;        alu_cy <= 1'b0; end
        default: alu_cy <= 1'b0;
      endcase
    end else begin
      alu_cy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_is_alu(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_LD, OP_AND, OP_OR, OP_XOR, OP_NOT};
  endfunction

  task automatic fill_rom(input logic [11:0] w);
    for (int i = 0; i < 256; i++) rom[i] = w;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"}, {24'd0, pc}, 32'd0);
    check({tag, "_ctl"}, {26'd0, alu_ce, cy_ce, busy, halted, 2'b00}, 32'd0);
    check({tag, "_op_ra"}, {25'd0, opcode, reg_addr}, 32'd0);
  endtask

  // Reset with start held high: reset must win and leave the DUT idle
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    m_acc = 8'h00;
    @(negedge clk);
    #1 check("idle_after_reset", {30'd0, busy, halted}, 32'd0);
  endtask

  // Start at pc=0 and step the reference model one instruction per 3 cycles
  task automatic run_prog(input int max_instr, input bit poke, output int cyc, output bit did_halt);
    logic [11:0] w;
    logic [3:0]  op;
    logic [7:0]  opd, r;
    logic [8:0]  t;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    m_pc = 8'h00; m_cf = 1'b0; cyc = 1; did_halt = 1'b0;
    for (int k = 0; k < max_instr; k++) begin
      #1;
      check("fetch_pc", {24'd0, pc}, {24'd0, m_pc});
      check("fetch_ctl", {28'd0, alu_ce, cy_ce, busy, halted}, 32'h2);
      @(negedge clk); cyc++;
      #1;
      check("decode_pc", {24'd0, pc}, {24'd0, m_pc});
      check("decode_ctl", {28'd0, alu_ce, cy_ce, busy, halted}, 32'h2);
      @(negedge clk); cyc++;
      #1;
      w = rom[m_pc]; op = w[11:8]; opd = w[7:0]; r = regs[opd[2:0]];
      check("exec_pc", {24'd0, pc}, {24'd0, m_pc});
      check("exec_ce", {30'd0, alu_ce, cy_ce},
            {30'd0, ref_is_alu(op), (op == OP_ADD) || (op == OP_SUB)});
      check("exec_op_ra", {25'd0, opcode, reg_addr}, {25'd0, op, opd[2:0]});
      check("exec_busy", {30'd0, busy, halted}, 32'h2);
      if (poke && $urandom_range(0, 2) == 0) start = 1'b1;
      case (op)
        OP_ADD: begin t = {1'b0, m_acc} + {1'b0, r}; m_acc = t[7:0]; m_cf = t[8]; m_pc++; end
        OP_SUB: begin t = {1'b0, m_acc} - {1'b0, r}; m_acc = t[7:0]; m_cf = t[8]; m_pc++; end
        OP_LD:  begin m_acc = r;         m_cf = 1'b0; m_pc++; end
        OP_AND: begin m_acc = m_acc & r; m_cf = 1'b0; m_pc++; end
        OP_OR:  begin m_acc = m_acc | r; m_cf = 1'b0; m_pc++; end
        OP_XOR: begin m_acc = m_acc ^ r; m_cf = 1'b0; m_pc++; end
        OP_NOT: begin m_acc = ~m_acc;    m_cf = 1'b0; m_pc++; end
        OP_JMP: m_pc = opd;
        OP_JC:  m_pc = m_cf ? opd : m_pc + 8'd1;
        OP_JNC: m_pc = m_cf ? m_pc + 8'd1 : opd;
        OP_HLT: did_halt = 1'b1;
        default: m_pc++;
      endcase
      @(negedge clk); cyc++;
      start = 1'b0;
      if (did_halt) begin
        #1;
        check("halt_ctl", {28'd0, alu_ce, cy_ce, busy, halted}, 32'h1);
        check("halt_pc", {24'd0, pc}, {24'd0, m_pc});
        check("halt_acc", {24'd0, acc}, {24'd0, m_acc});
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  cyc;
    bit  h;
    logic [3:0] op;
    fill_rom({OP_HLT, 8'h00});
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    m_acc = 8'h00;
    repeat (2) @(negedge clk);
    #1 check_all_zero("por");
    rst_n = 1'b1;
    do_reset();

    // LD r1, ADD r2, HLT
    regs[1] = 8'h0F; regs[2] = 8'h01;
    rom[0] = {OP_LD, 8'h01}; rom[1] = {OP_ADD, 8'h02}; rom[2] = {OP_HLT, 8'h00};
    run_prog(10, 1'b0, cyc, h);
    check("t1_halted", {31'd0, h}, 32'd1);
    check("t1_cycle", cyc, 32'd10);
    check("t1_acc", {24'd0, acc}, 32'h10);
    repeat (3) @(negedge clk);
    #1 check("t1_pc_hold", {23'd0, halted, pc}, 32'h102);

    // Carry survives an unknown opcode; JC taken
    fill_rom({OP_HLT, 8'h00});
    regs[1] = 8'hFF; regs[2] = 8'h01;
    rom[0] = {OP_LD, 8'h01}; rom[1] = {OP_ADD, 8'h02}; rom[2] = {4'hB, 8'h33};
    rom[3] = {OP_JC, 8'h07}; rom[4] = {OP_HLT, 8'h00}; rom[7] = {OP_HLT, 8'h00};
    run_prog(10, 1'b0, cyc, h);
    check("t2_jc_taken", {23'd0, halted, pc}, 32'h107);

    // No carry: JC falls through, JNC jumps
    regs[2] = 8'h00;
    run_prog(10, 1'b0, cyc, h);
    check("t3_jc_fall", {23'd0, halted, pc}, 32'h104);
    rom[3] = {OP_JNC, 8'h07};
    run_prog(10, 1'b0, cyc, h);
    check("t3_jnc_taken", {23'd0, halted, pc}, 32'h107);

    // JMP to the top address, then wrap back to 0
    fill_rom({OP_HLT, 8'h00});
    rom[0] = {OP_JMP, 8'hFF}; rom[255] = {4'h7, 8'h00};
    run_prog(4, 1'b0, cyc, h);
    check("t4_no_halt", {31'd0, h}, 32'd0);
    do_reset();

    // Reset in the middle of an ALU EXEC cycle, then restart from pc=0
    fill_rom({OP_HLT, 8'h00});
    regs[3] = 8'h5A;
    rom[0] = {OP_LD, 8'h03}; rom[1] = {OP_NOT, 8'h00}; rom[2] = {OP_HLT, 8'h00};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    check("t5_exec_ce", {31'd0, alu_ce}, 32'd1);
    rst_n = 1'b0;
    #1 check_all_zero("t5_rst");
    @(negedge clk); #1;
    check("t5_acc_untouched", {24'd0, acc}, 32'h00);
    @(negedge clk); rst_n = 1'b1; m_acc = 8'h00;
    run_prog(10, 1'b0, cyc, h);
    check("t5_restart_acc", {23'd0, h, acc}, 32'h1A5);

    // Randomized programs, with stray start pulses during EXEC
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) begin
        op = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 11) == 0) op = OP_HLT;
        else if (op == OP_HLT) op = OP_ADD;
        rom[i] = {op, 8'($urandom)};
      end
      run_prog(25, 1'b1, cyc, h);
      if (!h) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
